fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage RV64 pipeline. Holds the PC and drives the instruction-memory address. Captures the fetched word into IF/ID. Obeys the hazard unit's stall outputs (`pc_write`, `IF_ID_write`) and EX-stage branch redirects. Exports the IF/ID `rs1`/`rs2` fields that the hazard unit compares against ID/EX.

## Interface
- `XLEN`, 64, PC width.
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `NOP_INSTR`, 32'h00000013, bubble encoding (`addi x0,x0,0`).

- `clk`  in  1  pipeline clock.
- `reset`  in  1  synchronous, active-high; one clock, sampled on the rising edge of `clk`.
- `pc_write`  in  1  from hazard unit; 0 = hold PC.
- `IF_ID_write`  in  1  from hazard unit; 0 = hold IF/ID.
- `branch_taken`  in  1  EX-resolved redirect (branch taken or jump).
- `branch_target`  in  XLEN  redirect address.
- `imem_addr`  out  XLEN  current PC, combinational from the PC register.
- `imem_rdata`  in  32  instruction word at `imem_addr`.
- `imem_valid`  in  1  `imem_rdata` is valid this cycle.
- `IF_ID_pc`  out  XLEN  PC of the instruction in IF/ID.
- `IF_ID_instr`  out  32  instruction in IF/ID.
- `IF_ID_valid`  out  1  1 = real instruction, 0 = bubble.
- `IF_ID_rs1`  out  5  `IF_ID_instr[19:15]`, combinational.
- `IF_ID_rs2`  out  5  `IF_ID_instr[24:20]`, combinational.

## Operation
- `stall` = `!pc_write || !IF_ID_write`. A mismatched pair is treated as a full stall.
- Per rising edge, the first matching case applies:
  1. `reset`: PC <= `RESET_PC`; IF/ID <= {pc 0, `NOP_INSTR`, valid 0}.
  2. `branch_taken`: PC <= {`branch_target[XLEN-1:2]`, 2'b00}; IF/ID <= bubble (pc 0, `NOP_INSTR`, valid 0). The redirect overrides `stall`, because the stalled ID instruction is on the wrong path.
  3. `stall`: PC and all IF/ID fields hold.
  4. `!imem_valid`: PC holds; IF/ID <= bubble.
  5. Otherwise: IF/ID <= {PC, `imem_rdata`, 1}; PC <= PC + 4.
- PC + 4 wraps modulo 2^XLEN; no trap is raised.
- While IF/ID holds a bubble, `IF_ID_rs1` and `IF_ID_rs2` are 0, so the hazard unit never stalls on a bubble.
- The block has no other state; the two-state behaviour (valid/bubble) is carried entirely by `IF_ID_valid`.

## Timing
- Reset values: `imem_addr` = `RESET_PC`, `IF_ID_pc` = 0, `IF_ID_instr` = `NOP_INSTR`, `IF_ID_valid` = 0, `IF_ID_rs1` = 0, `IF_ID_rs2` = 0.
- Fetch latency is one cycle. The word presented at `imem_addr` in cycle N appears on the IF/ID outputs in cycle N+1.
- First fetch: in the first cycle after `reset` deasserts, `imem_addr` = `RESET_PC`. One edge later, IF/ID holds that word.
- Branch penalty: the edge with `branch_taken` puts a bubble in IF/ID. `imem_addr` = target in the next cycle, and the target instruction reaches IF/ID one edge after that.
- Stall: each stalled cycle holds every output unchanged. Stall release resumes with no lost or duplicated instruction.
- `reset` asserted mid-stall or mid-redirect wins outright on that edge.
- All outputs are either registered or decoded combinationally from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `pipe_pkg` holds `XLEN`, `NOP_INSTR`, the `RS1`/`RS2` field bit positions, and the IF/ID bundle typedef {pc, instr, valid}.
- One sub-module, `if_id_reg`. It takes `clk`, `reset`, `flush`, `hold` and the D bundle, and produces the Q bundle. The same register template is reused for ID/EX and later stages.
- The PC register and next-PC mux stay in `fetch_stage`.

## Test plan
- Reset, then imem returning 0x00500093 at 0x0 and 0x00108113 at 0x4 with `imem_valid`=1 → `IF_ID_pc`=0x0 and `IF_ID_instr`=0x00500093 (`IF_ID_rs1`=0, valid 1); next cycle `IF_ID_pc`=0x4, `IF_ID_rs1`=1.
- Load-use stall (`pc_write`=`IF_ID_write`=0) for 1 cycle at PC 0x8 → `imem_addr` stays 0x8 and IF/ID unchanged; next cycle PC=0xC with no duplicate instruction.
- `branch_taken`=1 with `branch_target`=0x103 while stalled → IF/ID becomes a bubble (valid 0, `NOP_INSTR`); `imem_addr`=0x100 next cycle; the instruction at 0x100 lands in IF/ID the cycle after.
- `imem_valid`=0 for 3 cycles at PC 0x20 → 3 bubbles enter IF/ID with PC held at 0x20; the word at 0x20 enters IF/ID on the first valid cycle.
- PC = 0xFFFF_FFFF_FFFF_FFFC, normal fetch → next PC = 0x0.
- `reset` asserted during a stall with PC=0x40 → PC=`RESET_PC` and IF/ID bubble on that edge, regardless of `branch_taken`.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, bubble encoding, register field
// positions and the IF/ID bundle carried between the fetch and decode stages.
package pipe_pkg;

    localparam int unsigned XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS1_MSB = 19;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RS2_MSB = 24;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b.pc    = '0;
        b.instr = nop;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: reset and flush load a bubble, hold freezes the
// contents, otherwise the D bundle is captured.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_d;
    if_id_t q_q;

    always_comb begin
        q_d = q_q;
        if (flush) begin
            q_d = if_id_bubble(NOP_INSTR);
        end else if (!hold) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= if_id_bubble(NOP_INSTR);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID
// register, honouring hazard-unit stalls and EX-stage redirects.
module fetch_stage #(
    parameter int unsigned XLEN      = pipe_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            IF_ID_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid,
    output logic [4:0]      IF_ID_rs1,
    output logic [4:0]      IF_ID_rs2
);

    import pipe_pkg::*;

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;
    logic            stall;
    if_id_t          if_id_d;
    if_id_t          if_id_q;

    // A half-asserted stall pair is treated as a full stall.
    assign stall = !pc_write || !IF_ID_write;

    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = {branch_target[XLEN-1:2], 2'b00};
        end else if (!stall && imem_valid) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        if_id_d = if_id_bubble(NOP_INSTR);
        if (imem_valid) begin
            if_id_d.pc    = pc_q;
            if_id_d.instr = imem_rdata;
            if_id_d.valid = 1'b1;
        end
    end

    // A redirect flushes even a stalled IF/ID: that instruction is on the wrong path.
    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .flush (branch_taken),
        .hold  (stall),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign imem_addr   = pc_q;
    assign IF_ID_pc    = if_id_q.pc;
    assign IF_ID_instr = if_id_q.instr;
    assign IF_ID_valid = if_id_q.valid;

    // Bubbles never expose register fields, so the hazard unit cannot stall on them.
    assign IF_ID_rs1 = if_id_q.valid ? if_id_q.instr[RS1_MSB:RS1_LSB] : 5'd0;
    assign IF_ID_rs2 = if_id_q.valid ? if_id_q.instr[RS2_MSB:RS2_LSB] : 5'd0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a per-edge behavioural model checked
// every cycle, plus directed literal expectations from the test plan.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        IF_ID_write;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [63:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_rs1;
    logic [4:0]  IF_ID_rs2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .IF_ID_write   (IF_ID_write),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_valid   (IF_ID_valid),
        .IF_ID_rs1     (IF_ID_rs1),
        .IF_ID_rs2     (IF_ID_rs2)
    );

    // Instruction memory contents: two fixed words, otherwise rs1=rs2=addr[6:2].
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'h0050_0093;
        if (a == 64'h4) return 32'h0010_8113;
        return {7'h0, a[6:2], a[6:2], 3'b000, 5'd1, 7'h13};
    endfunction

    always_comb imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the fetch rules applied once per rising edge.
    logic [63:0] m_pc;
    logic [63:0] m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid;
    bit          m_live = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 64'h0; m_ifpc = 64'h0; m_instr = NOP; m_valid = 0; m_live = 1;
        end else if (branch_taken) begin
            m_pc = branch_target & ~64'h3; m_ifpc = 64'h0; m_instr = NOP; m_valid = 0;
        end else if (!(pc_write && IF_ID_write)) begin
            // full hold
        end else if (!imem_valid) begin
            m_ifpc = 64'h0; m_instr = NOP; m_valid = 0;
        end else begin
            m_ifpc = m_pc; m_instr = mem_word(m_pc); m_valid = 1; m_pc = m_pc + 64'd4;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_if_id_pc", IF_ID_pc, m_ifpc);
            chk("m_if_id_instr", {32'h0, IF_ID_instr}, {32'h0, m_instr});
            chk("m_if_id_valid", {63'h0, IF_ID_valid}, {63'h0, m_valid});
            chk("m_if_id_rs1", {59'h0, IF_ID_rs1}, m_valid ? {59'h0, m_instr[19:15]} : 64'h0);
            chk("m_if_id_rs2", {59'h0, IF_ID_rs2}, m_valid ? {59'h0, m_instr[24:20]} : 64'h0);
        end
    end

    task automatic cyc(input logic rst, input logic pw, input logic iw, input logic bt,
                       input logic [63:0] bta, input logic iv);
        reset = rst; pc_write = pw; IF_ID_write = iw;
        branch_taken = bt; branch_target = bta; imem_valid = iv;
        @(posedge clk);
        #1;
    endtask

    task automatic run()  ; cyc(0, 1, 1, 0, 64'h0, 1); endtask
    task automatic jump(input logic [63:0] t); cyc(0, 1, 1, 1, t, 1); endtask

    initial begin
        reset = 1; pc_write = 1; IF_ID_write = 1; branch_taken = 0;
        branch_target = '0; imem_valid = 1;
        @(negedge clk);
        cyc(1, 1, 1, 0, 64'h0, 1);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", {63'h0, IF_ID_valid}, 64'h0);
        chk("rst_instr", {32'h0, IF_ID_instr}, {32'h0, NOP});
        chk("rst_rs1", {59'h0, IF_ID_rs1}, 64'h0);

        // First fetches
        run();
        chk("f0_pc", IF_ID_pc, 64'h0);
        chk("f0_instr", {32'h0, IF_ID_instr}, 64'h0050_0093);
        chk("f0_valid", {63'h0, IF_ID_valid}, 64'h1);
        run();
        chk("f1_pc", IF_ID_pc, 64'h4);
        chk("f1_rs1", {59'h0, IF_ID_rs1}, 64'h1);
        chk("f1_addr", imem_addr, 64'h8);

        // Load-use stall at 0x8, then resume
        cyc(0, 0, 0, 0, 64'h0, 1);
        chk("st_addr", imem_addr, 64'h8);
        chk("st_pc", IF_ID_pc, 64'h4);
        run();
        chk("st_rel_pc", IF_ID_pc, 64'h8);
        chk("st_rel_addr", imem_addr, 64'hC);

        // Mismatched stall pair holds too
        cyc(0, 1, 0, 0, 64'h0, 1);
        chk("half_addr", imem_addr, 64'hC);
        chk("half_pc", IF_ID_pc, 64'h8);

        // Redirect while stalled
        cyc(0, 0, 0, 1, 64'h103, 1);
        chk("br_valid", {63'h0, IF_ID_valid}, 64'h0);
        chk("br_instr", {32'h0, IF_ID_instr}, {32'h0, NOP});
        chk("br_addr", imem_addr, 64'h100);
        run();
        chk("br_tgt_pc", IF_ID_pc, 64'h100);

        // imem not ready for 3 cycles at 0x20
        jump(64'h20);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 64'h0, 0);
            chk("iv0_valid", {63'h0, IF_ID_valid}, 64'h0);
            chk("iv0_addr", imem_addr, 64'h20);
        end
        run();
        chk("iv1_pc", IF_ID_pc, 64'h20);
        chk("iv1_valid", {63'h0, IF_ID_valid}, 64'h1);

        // PC wrap
        jump(64'hFFFF_FFFF_FFFF_FFFC);
        run();
        chk("wrap_pc", IF_ID_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr", imem_addr, 64'h0);

        // Reset during stall, without and with a redirect
        jump(64'h40);
        cyc(1, 0, 0, 0, 64'h0, 1);
        chk("rs_addr", imem_addr, 64'h0);
        chk("rs_valid", {63'h0, IF_ID_valid}, 64'h0);
        jump(64'h40);
        cyc(1, 0, 0, 1, 64'h200, 1);
        chk("rsb_addr", imem_addr, 64'h0);
        chk("rsb_valid", {63'h0, IF_ID_valid}, 64'h0);

        // Mixed traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            cyc(0, ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                ($urandom_range(0, 7) == 0), {52'h0, 12'($urandom_range(0, 4095))},
                ($urandom_range(0, 3) != 0));
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
